// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - state_t     : FSM state encoding (IDLE, SHIFT, DONE), 2 bits
//   - cnt_width() : width of the bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The counter must be able to represent WIDTH itself so that it never
    // wraps within one operation.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Existing combinational 1-bit full-adder cell, used as the single slice of
// the bit-serial adder.
// Ports:
//   a, b      : operand bits
//   carry_in  : incoming carry
//   sum       : a ^ b ^ carry_in
//   carry_out : majority(a, b, carry_in)
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, one bit
// per clock, LSB first. An accepted start loads the operands; WIDTH SHIFT
// cycles later the result is transferred to sum/cout and done pulses once.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, honoured only when idle
//   a, b  : operands (WIDTH bits), captured on accepted start
//   cin   : carry-in, captured on accepted start
//   busy  : high while in SHIFT or DONE
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result, held until the next accepted start completes
//   cout  : final carry-out, held with sum
// ----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_next;

    full_adder u_slice (
        .a         (opa_sr[0]),
        .b         (opb_sr[0]),
        .carry_in  (carry),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    // Slice sum enters at the MSB; taking the upper WIDTH bits of the
    // extended vector keeps the shift legal even for WIDTH=1.
    assign res_ext  = {fa_sum, res_sr};
    assign res_next = res_ext[WIDTH:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            opa_sr <= '0;
            opb_sr <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa_sr <= a;
                        opb_sr <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    opa_sr <= opa_sr >> 1;
                    opb_sr <= opb_sr >> 1;
                    res_sr <= res_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        // Last bit: publish result together with the final carry.
                        sum   <= res_next;
                        cout  <= fa_cout;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). A timeline model derives the
// expected busy/done/sum/cout from the arithmetic a+b+cin and the handshake
// timing; directed vectors add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: m_k counts edges since the accepting edge (-1 when idle).
    int             m_k = -1;
    logic           m_valid = 1'b0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [WIDTH:0] m_res = '0;
    logic [WIDTH:0] m_out = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_k     = -1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_out   = '0;
        end else if (m_k < 0) begin
            m_done = 1'b0;
            if (start) begin
                m_res  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                m_k    = 0;
                m_busy = 1'b1;
            end
        end else begin
            m_k    = m_k + 1;
            m_done = (m_k == WIDTH);
            if (m_k == WIDTH) m_out = m_res;
            if (m_k == WIDTH + 1) begin
                m_k    = -1;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (m_valid)
            chk("cycle", {22'd0, busy, done, cout, sum}, {22'd0, m_busy, m_done, m_out});
    end

    // Start one add, wait for done, check latency and literal result.
    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic tc, input logic [WIDTH-1:0] esum, input logic ecout);
        int k;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, WIDTH);
        chk("sum", {24'd0, sum}, {24'd0, esum});
        chk("cout", {31'd0, cout}, {31'd0, ecout});
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int last_done;
        int gaps_bad;

        // Reset
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {28'd0, busy, done, cout, 1'b0} | {24'd0, sum}, 32'd0);

        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start ignored while busy
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin a = 8'h80; b = 8'h80; start = 1'b1; end
            else start = 1'b0;
            if (done) begin
                ndone++;
                chk("ign_sum", {23'd0, cout, sum}, 32'h002);
            end
            @(negedge clk);
        end
        chk("ign_ndone", ndone, 1);

        // Reset in the middle of an add
        a = 8'hC3; b = 8'h77; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", {22'd0, busy, done, cout, sum}, 32'd0);
        run_add(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // Back-to-back with start held high
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        ndone = 0; last_done = -1; gaps_bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            a = a + 8'h11; b = b + 8'h07;
            if (done) begin
                if (last_done >= 0 && (i - last_done) != 10) gaps_bad++;
                last_done = i;
                ndone++;
            end
        end
        start = 1'b0;
        for (int i = 32; i < 48; i++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0 && (i - last_done) != 10) gaps_bad++;
                last_done = i;
                ndone++;
            end
        end
        chk("b2b_ndone", ndone, 4);
        chk("b2b_gaps", gaps_bad, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
